// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers; stores {source id, data}.
// Latency: grant is combinational, word visible on dout the cycle after its push edge (FWFT read).
// Backpressure: no grant while full unless the consumer pops in the same cycle; losers hold req/din.
module fifo_rr_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 4,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          rd,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [ID_WIDTH-1:0]           dout_id,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_dat [DEPTH];
  logic [ID_WIDTH-1:0]   mem_id  [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] din_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  pop;
  logic                  push;
  logic                  accept;

  assign count   = cnt;
  assign empty   = (cnt == CW'(0));
  assign full    = (cnt == CW'(DEPTH));
  assign pop     = rd & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign accept  = ~full | pop;
  assign push    = |gnt;
  assign dout    = mem_dat[rd_ptr];
  assign dout_id = mem_id[rd_ptr];

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      din_arr[i] = din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pick the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    if (accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // rr_ptr < NUM_REQ and k < NUM_REQ, so one subtraction is enough to wrap.
        sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
        if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
          sum = sum - (ID_WIDTH+1)'(NUM_REQ);
        end
        cand = sum[ID_WIDTH-1:0];
        if (!found && req[cand]) begin
          found      = 1'b1;
          gnt[cand]  = 1'b1;
          gnt_idx    = cand;
        end
      end
    end
  end

  // Pointers, occupancy and round-robin state; reset discards everything at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + ID_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; cleared on reset so an empty FIFO presents zeros on dout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_id[i]  <= '0;
      end
    end else if (push) begin
      mem_dat[wr_ptr] <= din_arr[gnt_idx];
      mem_id[wr_ptr]  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Bench for fifo_rr_write_arbiter: directed grant vectors plus a random fill/drain phase.
// Stimulus pushes expected grant/count/word into queues; a monitor compares before each edge.
// Inputs are driven after the falling edge and returned to idle right after the rising edge.
module tb_fifo_rr_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int DP = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] din = '0;
  logic             rd = 1'b0;
  logic [NR-1:0]    gnt;
  logic [DW-1:0]    dout;
  logic [IW-1:0]    dout_id;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;

  fifo_rr_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DEPTH(DP)) dut (
    .clk(clk), .resetn(resetn), .req(req), .din(din), .gnt(gnt), .rd(rd),
    .dout(dout), .dout_id(dout_id), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [NR-1:0]    gnt_q[$];
  int               cnt_q[$];
  logic [IW+DW-1:0] data_q[$];
  int               model_rr = 0;
  int               model_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter used for the random phase.
  function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r, input logic rdv);
    logic [NR-1:0] g;
    logic pop_m, acc, found;
    g = '0;
    found = 1'b0;
    pop_m = rdv && (model_count > 0);
    acc = (model_count < DP) || pop_m;
    if (acc) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (model_rr + k) % NR;
        if (!found && r[i]) begin
          g[i] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // One transaction cycle with its expected grant.
  task automatic drive(input logic [NR-1:0] r, input logic [NR*DW-1:0] d,
                       input logic rdv, input logic [NR-1:0] eg);
    int pop_m, push_m;
    @(negedge clk);
    #1;
    req = r;
    din = d;
    rd  = rdv;
    gnt_q.push_back(eg);
    cnt_q.push_back(model_count);
    pop_m  = (rdv && model_count > 0) ? 1 : 0;
    push_m = 0;
    for (int i = 0; i < NR; i++) begin
      if (eg[i]) begin
        data_q.push_back({IW'(i), d[i*DW +: DW]});
        model_rr = (i + 1) % NR;
        push_m = 1;
      end
    end
    model_count = model_count + push_m - pop_m;
    @(posedge clk);
    #1;
    req = '0;
    rd  = 1'b0;
  endtask

  // Scoreboard monitor: compares just before each rising edge of a driven cycle.
  initial begin
    logic [NR-1:0]    eg;
    int               ec;
    logic [IW+DW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (gnt_q.size() > 0) begin
        eg = gnt_q.pop_front();
        ec = cnt_q.pop_front();
        check("gnt", 32'(gnt), 32'(eg));
        check("count", 32'(count), ec);
        check("empty", 32'(empty), 32'(ec == 0));
        check("full", 32'(full), 32'(ec == DP));
        if (rd && !empty) begin
          if (data_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_extra: popped %0h/%0h but no word expected", dout, dout_id);
          end else begin
            e = data_q.pop_front();
            check("dout", 32'(dout), 32'(e[DW-1:0]));
            check("dout_id", 32'(dout_id), 32'(e[DW +: IW]));
          end
        end
      end
    end
  end

  localparam logic [NR*DW-1:0] D2 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [NR*DW-1:0] D3 = {8'h00, 8'h77, 8'h00, 8'h00};
  localparam logic [NR*DW-1:0] D4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  initial begin
    logic [NR-1:0]    g4 [6];
    logic [NR-1:0]    r;
    logic [NR*DW-1:0] d;
    logic             rdv;
    logic [NR-1:0]    eg;
    int               pushed;

    // 1: reset state, then asynchronous reset in the middle of operation.
    repeat (2) @(posedge clk);
    #2;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_dout", 32'(dout), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) drive(4'b0001, {24'h0, 8'h5A}, 1'b0, 4'b0001);
    check("pre_reset_count", 32'(count), 3);
    #2;
    resetn = 1'b0;
    #1;
    check("async_count", 32'(count), 0);
    check("async_empty", 32'(empty), 1);
    check("async_dout", 32'(dout), 0);
    check("async_dout_id", 32'(dout_id), 0);
    data_q.delete();
    model_rr = 0;
    model_count = 0;
    @(negedge clk);
    resetn = 1'b1;

    // 2: all requesting, fill in order 0..3, then full blocks grants.
    drive(4'b1111, D2, 1'b0, 4'b0001);
    drive(4'b1111, D2, 1'b0, 4'b0010);
    drive(4'b1111, D2, 1'b0, 4'b0100);
    drive(4'b1111, D2, 1'b0, 4'b1000);
    drive(4'b1111, D2, 1'b0, 4'b0000);
    check("full_after_fill", 32'(full), 1);

    // 3: push into full FIFO alongside a pop; occupancy holds at DEPTH.
    drive(4'b0100, D3, 1'b1, 4'b0100);
    check("full_push_pop_count", 32'(count), 4);
    repeat (4) drive(4'b0000, '0, 1'b1, 4'b0000);
    check("drained_empty", 32'(empty), 1);

    // 4: alternating requesters with a pop every cycle; rr_ptr wraps from 3.
    g4 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int i = 0; i < 6; i++) drive(4'b0101, D4, 1'b1, g4[i]);
    check("alt_count", 32'(count), 1);
    drive(4'b0000, '0, 1'b1, 4'b0000);

    // 5: pop while empty is ignored; head stays on the stale slot 3 word (A0 from requester 0).
    repeat (2) drive(4'b0000, '0, 1'b1, 4'b0000);
    check("empty_rd_count", 32'(count), 0);
    check("empty_rd_dout", 32'(dout), 32'h A0);
    check("empty_rd_dout_id", 32'(dout_id), 0);

    // 6: random traffic for at least 3*DEPTH words, then drain.
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 3*DP; c++) begin
      r   = NR'($urandom_range(0, (1 << NR) - 1));
      d   = $urandom;
      rdv = 1'($urandom_range(0, 1));
      eg  = model_gnt(r, rdv);
      drive(r, d, rdv, eg);
      if (eg != '0) pushed++;
    end
    check("random_words_pushed", 32'(pushed >= 3*DP), 1);
    for (int k = 0; k < DP + 4 && model_count > 0; k++) drive(4'b0000, '0, 1'b1, 4'b0000);
    @(negedge clk);
    #4;
    check("scoreboard_drained", 32'(data_q.size()), 0);
    check("final_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
- Shares one multi-bit FIFO write port among NUM_REQ requesters using round-robin arbitration.
- Each accepted word is stored together with the index of the requester that sent it.
- The read side is first-word-fall-through with a pop strobe.
- The block sits between several producer blocks and a single consumer.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- NUM_REQ, 4, number of requesters (2..16).
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.
- ID_WIDTH, $clog2(NUM_REQ) (derived, localparam), width of the source tag.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- din  input  NUM_REQ*DATA_WIDTH  requester i data on bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot grant, combinational; requester i's word is accepted at the next rising edge when gnt[i]=1.
- rd  input  1  pop strobe from the consumer.
- dout  output  DATA_WIDTH  head-entry data.
- dout_id  output  ID_WIDTH  head-entry source index.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (resetn low, asynchronous):
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - Round-robin pointer rr_ptr = 0.
  - Storage is cleared to 0, so dout = 0 and dout_id = 0.
  - Asserting reset mid-operation discards all stored entries immediately.
  - Release of resetn is sampled on clk.
- Pop:
  - pop = rd & ~empty.
  - rd while empty is ignored: no pointer change, no underflow.
- Accept condition: accept = (~full) | pop.
  - Pushing into a full FIFO is allowed in the same cycle as a pop.
- Grant:
  - When accept=1 and |req, gnt selects the first requester with req set, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Otherwise gnt = 0.
  - gnt is at most one-hot.
  - gnt never asserts for a requester whose req=0.
- Push: on a rising edge with gnt[i]=1:
  - mem[wr_ptr] <= {i, din[i]}.
  - wr_ptr increments, wrapping modulo DEPTH.
  - rr_ptr <= (i+1) mod NUM_REQ.
- rr_ptr is unchanged when no grant is issued.
- Read side: dout/dout_id = mem[rd_ptr] combinationally (zero-latency head); pop increments rd_ptr modulo DEPTH.
- Count:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - full = (count == DEPTH); empty = (count == 0), both registered or derived from count.
- Simultaneous push and pop on an empty FIFO cannot occur, because pop requires ~empty. A word pushed into an empty FIFO becomes visible on dout the cycle after the push edge.
- Fairness: with all req held high, requesters are granted in the order 0,1,...,NUM_REQ-1,0,... A requester waits at most NUM_REQ-1 grants.
- Requesters may drop req without being granted; no state is retained per requester.
- A requester must hold req and din stable until granted.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0, gnt=0, dout=0; assert resetn low mid-operation with count=3 -> count=0 and empty=1 immediately, without waiting for a clock edge.
2. req=4'b1111, din={8'h44,8'h33,8'h22,8'h11}, rd=0 for 4 cycles -> gnt sequence 0001,0010,0100,1000; then full=1 and gnt=0. Pops give dout/dout_id 11/0, 22/1, 33/2, 44/3.
3. FIFO full, req[2]=1, rd=1 in the same cycle -> gnt=0100, count stays 4, head advances, and the new entry lands at the tail with id=2.
4. req=4'b0101 held with rd=1 every cycle for 6 cycles -> grants alternate 0001,0100; rr_ptr wraps; count stays <= 1.
5. rd=1 while empty -> no change in count or pointers, dout stable.
6. Fill and drain 3*DEPTH words with random req/rd -> the scoreboard matches data/id order, and no word is lost or duplicated across pointer wrap.
